// File: rtl/alu_pkg.sv
// Shared ALU types: operation codes, FSM states, shift classification.
// No logic latency; pure declarations.
// No backpressure; consumed by the decoder and execute unit.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLL  = 4'b0110,
        ALU_SLTU = 4'b1000,
        ALU_SRL  = 4'b1001,
        ALU_SRA  = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } alu_state_e;

    // Canonical undefined code; every other unlisted code is also illegal.
    localparam logic [3:0] ALU_OP_INVALID = 4'b0111;

    // Shifts go through the iterative shifter rather than alu_core.
    function automatic logic is_shift_op(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU for non-shift operations plus illegal-code detection.
// Zero latency.
// No backpressure; the execute unit registers the result.
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [3:0]            ALUControl,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  Illegal
);

    // Decode the operation; shift codes are legal but produced elsewhere,
    // illegal codes force a zero result.
    always_comb begin
        Result  = '0;
        Illegal = 1'b0;
        case (ALUControl)
            ALU_ADD:  Result = SrcA + SrcB;
            ALU_SUB:  Result = SrcA - SrcB;
            ALU_AND:  Result = SrcA & SrcB;
            ALU_OR:   Result = SrcA | SrcB;
            ALU_XOR:  Result = SrcA ^ SrcB;
            ALU_SLT:  Result = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            ALU_SLTU: Result = {{(DATA_WIDTH-1){1'b0}}, (SrcA < SrcB)};
            ALU_SLL, ALU_SRL, ALU_SRA: Result = '0;
            default:  Illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: registered result, zero flag and illegal flag.
// Latency 1 cycle for single-cycle ops and shift-by-0, n+1 cycles for shift by n.
// in_ready drops while shifting or while a result waits on out_ready; flush wins.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            ALUControl,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  Zero,
    output logic                  IllegalOp
);

    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    alu_state_e            state_q;
    logic [SHAMT_W-1:0]    cnt_q;
    logic [DATA_WIDTH-1:0] work_q;
    logic [3:0]            shop_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  zero_q;
    logic                  illegal_q;
    logic                  out_valid_q;

    logic [DATA_WIDTH-1:0] core_res;
    logic                  core_ill;
    logic [DATA_WIDTH-1:0] shift_d;
    logic [DATA_WIDTH-1:0] acc_res_d;
    logic [SHAMT_W-1:0]    shamt;
    logic                  in_shift;
    logic                  accept;

    alu_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .Result     (core_res),
        .Illegal    (core_ill)
    );

    assign shamt    = SrcB[SHAMT_W-1:0];
    assign in_shift = is_shift_op(ALUControl);
    assign in_ready = !flush && ((state_q == ST_IDLE) ||
                                 ((state_q == ST_DONE) && out_ready));
    assign accept   = in_valid && in_ready;

    // A shift by zero returns SrcA unchanged through the single-cycle path.
    assign acc_res_d = in_shift ? SrcA : core_res;

    // One-bit step of the iterative shifter; SRA refills with the sign bit.
    always_comb begin
        shift_d = work_q;
        case (shop_q)
            ALU_SLL: shift_d = {work_q[DATA_WIDTH-2:0], 1'b0};
            ALU_SRL: shift_d = {1'b0, work_q[DATA_WIDTH-1:1]};
            default: shift_d = {work_q[DATA_WIDTH-1], work_q[DATA_WIDTH-1:1]};
        endcase
    end

    // Control FSM with registered result outputs; flush overrides any
    // acceptance or shift in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            shop_q      <= 4'b0000;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            if (in_shift && (shamt != '0)) begin
                state_q     <= ST_BUSY;
                cnt_q       <= shamt;
                work_q      <= SrcA;
                shop_q      <= ALUControl;
                out_valid_q <= 1'b0;
            end else begin
                state_q     <= ST_DONE;
                result_q    <= acc_res_d;
                zero_q      <= (acc_res_d == '0);
                illegal_q   <= core_ill;
                out_valid_q <= 1'b1;
            end
        end else begin
            case (state_q)
                ST_BUSY: begin
                    work_q <= shift_d;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == SHAMT_W'(1)) begin
                        state_q     <= ST_DONE;
                        result_q    <= shift_d;
                        zero_q      <= (shift_d == '0);
                        illegal_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign IllegalOp = illegal_q;

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage ALU that consumes the 4-bit `ALUControl` code produced by the control unit's ALU decoder, together with the two source operands. It returns a registered result and a zero flag. Single-cycle operations complete in one cycle. Shifts run on an iterative one-bit-per-cycle shifter, and a valid/ready handshake on both sides lets the pipeline stall around them. It sits between the ID/EX operand latch and the EX/MEM register.

## Interface
- `DATA_WIDTH`, 32, operand/result width; power of two.
- `SHAMT_W`, `$clog2(DATA_WIDTH)`, shift-amount width; derived, not overridden.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous pipeline flush.
- `in_valid` in 1: operands and `ALUControl` valid.
- `in_ready` out 1: unit can accept.
- `ALUControl` in 4: operation code.
- `SrcA` in `DATA_WIDTH`: operand A.
- `SrcB` in `DATA_WIDTH`: operand B; bits `[SHAMT_W-1:0]` are the shift amount.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer takes result.
- `ALUResult` out `DATA_WIDTH`: registered result.
- `Zero` out 1: `ALUResult == 0`.
- `IllegalOp` out 1: code was not a defined operation.

## Operation
- **Encodings:**
  - 0000 ADD; 0001 SUB; 0010 AND; 0011 OR; 0100 XOR; 0101 SLT.
  - 0110 SLL; 1000 SLTU; 1001 SRL; 1010 SRA.
  - 0111 and every other unlisted code is invalid.
- **Arithmetic:**
  - ADD and SUB wrap modulo 2^DATA_WIDTH.
  - SLT is a signed compare and SLTU an unsigned compare; both produce a zero-extended 0 or 1.
- **Shifts:**
  - Shift amount is `SrcB[SHAMT_W-1:0]`; upper `SrcB` bits are ignored.
  - Each BUSY cycle shifts by one bit.
  - SRA replicates the MSB on every step; SRL and SLL insert 0.
- **Illegal code:** `ALUResult` = 0, `Zero` = 1, `IllegalOp` = 1; takes the single-cycle path.
- **FSM states:**
  - IDLE: no result held.
  - BUSY: shifting; holds the working value and a down-counter of remaining shifts.
  - DONE: result held.
- **`in_ready`:** combinational. It equals `!flush && (IDLE || (DONE && out_ready))`.
- **Acceptance:** occurs on `in_valid && in_ready`.
  - Non-shift, illegal, or shift-by-0: result is registered and the FSM goes to DONE.
  - Shift by n>0: the FSM goes to BUSY with count = n.
- **BUSY:** each cycle shifts by one bit and decrements the count. When the count reaches 1, the final value is registered and the FSM goes to DONE.
- **DONE:**
  - `out_valid` = 1; `ALUResult`, `Zero` and `IllegalOp` are held stable until `out_ready`.
  - On `out_ready` without a new acceptance, the FSM goes to IDLE.
  - On `out_ready` with a new acceptance in the same cycle, the new operation is taken back-to-back with no bubble.
- **`flush`:** wins over everything. It goes to IDLE, deasserts `out_valid` next cycle, drops any in-progress shift, and accepts nothing that cycle.

## Timing
- **Reset (`rst_n` low, async):**
  - State = IDLE.
  - `out_valid` = 0, `ALUResult` = 0, `Zero` = 0, `IllegalOp` = 0.
  - `in_ready` = 1 once the state is IDLE.
- **Reset mid-shift:** aborts immediately; no partial result is ever presented.
- **Latency:**
  - Non-shift, illegal, or shift-by-0: 1 cycle from acceptance edge to `out_valid`.
  - Shift by n: n+1 cycles.
  - Worst case: `DATA_WIDTH` cycles (shift by 31).
- **Throughput:** 1 op/cycle for single-cycle ops with `out_ready` held high.
- **Input hold:** operands are sampled only at acceptance; they may change afterward.
- **`in_ready` in BUSY:** 0; `out_valid` in BUSY: 0.
- **`out_valid`:** once high, never drops without `out_ready` or `flush`.

## Structure
- Package `alu_pkg`:
  - `alu_op_e` enum with the encodings above.
  - `alu_state_e` for IDLE, BUSY and DONE.
  - `ALU_OP_INVALID` constant.
  - The decoder uses the same package.
- Sub-module `alu_core`: purely combinational. It computes ADD/SUB/AND/OR/XOR/SLT/SLTU and the illegal flag from `(ALUControl, SrcA, SrcB)`.
- The shifter, counter and FSM live in `alu_exec_unit`.

## Test plan
- **ADD/SUB wrap:** ADD 0xFFFFFFFF+1 -> result 0x0, `Zero`=1, `out_valid` 1 cycle after accept. SUB 5-7 -> 0xFFFFFFFE, `Zero`=0.
- **SLT vs SLTU:** SrcA=0xFFFFFFFF, SrcB=1. SLT -> 1; SLTU -> 0.
- **Shifts:**
  - SRA 0x80000000 by 4 -> 0xF8000000, `out_valid` 5 cycles after accept, `in_ready`=0 meanwhile.
  - SLL by 0 -> 1 cycle.
  - SRL 0x80000000 by 31 -> 0x1 after 32 cycles.
- **Backpressure:**
  - Hold `out_ready`=0 for 3 cycles after ADD: result stable, `in_ready`=0.
  - Raise `out_ready` with a second ADD valid: the second op is accepted the same cycle and its result appears the next cycle.
- **Illegal:** code 0111 -> `ALUResult`=0, `IllegalOp`=1, `Zero`=1 after 1 cycle.
- **Flush/reset:**
  - `flush` in cycle 2 of an SLL by 10 -> IDLE next cycle, `out_valid` never rises.
  - `rst_n` low mid-shift -> all outputs 0 asynchronously; a new ADD is accepted after release.
